// File: rtl/ifu_fetch_queue_pkg.sv
// ifu_fetch_queue_pkg: shared widths, reset PC and fetch FSM encodings
package ifu_fetch_queue_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
endpackage

// File: rtl/ifu_fetch_queue_if.sv
// ifu_fetch_queue_if: imem request/response, redirect and pre-decode handshake bundle
interface ifu_fetch_queue_if;
   import ifu_fetch_queue_pkg::*;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            imem_rsp_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_inst;
   modport master (
      output imem_req_valid, imem_req_addr, imem_rsp_ready, out_valid, out_pc, out_inst,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, imem_rsp_ready, out_valid, out_pc, out_inst,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/ifu_fetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count, head read from storage
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;
   // storage write; the caller never pushes while full
   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr] <= i_data;
   // pointers wrap naturally at power-of-2 depth; flush empties the queue
   always_ff @(posedge clk)
      if (!rst || i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
      end
endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: fetch PC + single-outstanding imem FSM feeding a {pc,inst} FIFO
module ifu_fetch_queue
   import ifu_fetch_queue_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              DEPTH    = 4
) (
   input logic              clk,
   input logic              rst,
   ifu_fetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   state_t            r_state;
   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   r_req_pc;
   logic [CW-1:0]     w_count;
   logic [2*XLEN-1:0] w_head;
   logic              w_full;
   logic              w_req_valid;
   logic              w_req_fire;
   logic              w_push;
   logic              w_out_valid;
   logic              w_pop;
   assign w_full      = w_count == CW'(DEPTH);
   assign w_req_valid = rst & (r_state == S_REQ) & ~w_full & ~bus.redirect_valid;
   assign w_req_fire  = w_req_valid & bus.imem_req_ready;
   assign w_push      = (r_state == S_WAIT) & bus.imem_rsp_valid & ~bus.redirect_valid;
   assign w_out_valid = rst & (w_count != '0) & ~bus.redirect_valid;
   assign w_pop       = w_out_valid & bus.out_ready;
   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = {r_fetch_pc[XLEN-1:2], 2'b00};
   assign bus.imem_rsp_ready = 1'b1;
   assign bus.out_valid      = w_out_valid;
   assign bus.out_pc         = w_head[2*XLEN-1:XLEN];
   assign bus.out_inst       = w_head[XLEN-1:0];
   // fetch FSM: redirect wins; a response still in flight after redirect is dropped
   always_ff @(posedge clk)
      if (!rst) begin
         r_state    <= S_REQ;
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
      end else if (bus.redirect_valid) begin
         r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         r_state    <= (r_state == S_REQ || bus.imem_rsp_valid) ? S_REQ : S_DROP;
      end else begin
         case (r_state)
            S_REQ:
               if (w_req_fire) begin
                  r_req_pc   <= r_fetch_pc;
                  r_fetch_pc <= r_fetch_pc + 32'd4;
                  r_state    <= S_WAIT;
               end
            S_WAIT, S_DROP:
               if (bus.imem_rsp_valid) r_state <= S_REQ;
            default: r_state <= S_REQ;
         endcase
      end
   fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.redirect_valid),
      .i_push  (w_push),
      .i_data  ({r_req_pc, bus.imem_rsp_data}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count)
   );
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: directed vectors plus hand sequences for flush/full/reset corners
module tb_ifu_fetch_queue;
   import ifu_fetch_queue_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   ifu_fetch_queue_if bus();
   ifu_fetch_queue #(.RESET_PC(32'h8000_0000), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );
   typedef struct {
      logic        rd;
      logic [31:0] rpc;
      logic        ordy;
      logic        rv;
      logic [31:0] addr;
      logic        ov;
      logic [31:0] pc;
   } vec_t;
   vec_t        tv [12];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat = 1;
   int          cnt = 0;
   logic [31:0] pend_addr = '0;
   logic        o_rv, o_ov;
   logic [31:0] o_addr, o_pc, o_inst;
   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // one clock: drive inputs after negedge, imem model answers lat cycles after accept
   task automatic cyc(input logic rs, input logic rd, input logic [31:0] rpc,
                      input logic ordy, input logic qrdy);
      @(negedge clk);
      rst = rs;
      bus.redirect_valid = rd;
      bus.redirect_pc    = rpc;
      bus.out_ready      = ordy;
      bus.imem_req_ready = qrdy;
      bus.imem_rsp_valid = 1'b0;
      if (cnt > 0) begin
         cnt--;
         bus.imem_rsp_valid = (cnt == 0);
         bus.imem_rsp_data  = f(pend_addr);
      end
      #1;
      o_rv = bus.imem_req_valid; o_addr = bus.imem_req_addr;
      o_ov = bus.out_valid; o_pc = bus.out_pc; o_inst = bus.out_inst;
      if (o_rv && qrdy) begin
         cnt = lat;
         pend_addr = o_addr;
      end
   endtask
   task automatic expect_out(input string nm, input logic rv, input logic [31:0] addr,
                             input logic ov, input logic [31:0] pc);
      chk({nm, ".req_valid"}, {31'b0, o_rv}, {31'b0, rv});
      if (rv) chk({nm, ".req_addr"}, o_addr, addr);
      chk({nm, ".out_valid"}, {31'b0, o_ov}, {31'b0, ov});
      if (ov) begin
         chk({nm, ".out_pc"}, o_pc, pc);
         chk({nm, ".out_inst"}, o_inst, f(pc));
      end
   endtask
   task automatic do_reset();
      cnt = 0;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
         expect_out("reset", 1'b0, '0, 1'b0, '0);
      end
   endtask
   initial begin
      bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
      bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b1;
      tv[0]  = '{0, 0, 1, 1, 32'h8000_0000, 0, 0};
      tv[1]  = '{0, 0, 1, 0, 0,             0, 0};
      tv[2]  = '{0, 0, 1, 1, 32'h8000_0004, 1, 32'h8000_0000};
      tv[3]  = '{0, 0, 1, 0, 0,             0, 0};
      tv[4]  = '{0, 0, 1, 1, 32'h8000_0008, 1, 32'h8000_0004};
      tv[5]  = '{0, 0, 1, 0, 0,             0, 0};
      tv[6]  = '{0, 0, 1, 1, 32'h8000_000C, 1, 32'h8000_0008};
      tv[7]  = '{0, 0, 1, 0, 0,             0, 0};
      tv[8]  = '{1, 32'h8000_0102, 1, 0, 0, 0, 0};
      tv[9]  = '{0, 0, 1, 1, 32'h8000_0100, 0, 0};
      tv[10] = '{0, 0, 1, 0, 0,             0, 0};
      tv[11] = '{0, 0, 1, 1, 32'h8000_0104, 1, 32'h8000_0100};
      // streaming from reset, then a redirect in S_REQ with an entry buffered
      do_reset();
      lat = 1;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, tv[i].rd, tv[i].rpc, tv[i].ordy, 1'b1);
         expect_out($sformatf("vec%0d", i), tv[i].rv, tv[i].addr, tv[i].ov, tv[i].pc);
      end
      chk("rsp_ready", {31'b0, bus.imem_rsp_ready}, 32'd1);
      // backpressure: four entries fill, requests stop
      do_reset();
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (i >= 8) expect_out($sformatf("full%0d", i), 1'b0, '0, 1'b1, 32'h8000_0000);
      end
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
      expect_out("popA", 1'b0, '0, 1'b1, 32'h8000_0000);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      expect_out("resume", 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0004);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("pushpop", 1'b0, '0, 1'b1, 32'h8000_0004);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
      expect_out("cnt3", 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0008);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
         expect_out($sformatf("drain%0d", i), 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0008 + 32'(4 * i));
      end
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
      expect_out("drained", 1'b1, 32'h8000_0014, 1'b0, '0);
      // redirect while waiting on a slow response
      do_reset();
      lat = 3;
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rw0", 1'b1, 32'h8000_0000, 1'b0, '0);
      cyc(1'b1, 1'b1, 32'h8000_0100, 1'b1, 1'b1);
      expect_out("rw1", 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rw2", 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rw3", 1'b0, '0, 1'b0, '0);
      lat = 1;
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rw4", 1'b1, 32'h8000_0100, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rw5", 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rw6", 1'b1, 32'h8000_0104, 1'b1, 32'h8000_0100);
      // redirect coincident with the response
      do_reset();
      lat = 1;
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rc0", 1'b1, 32'h8000_0000, 1'b0, '0);
      cyc(1'b1, 1'b1, 32'h8000_0300, 1'b1, 1'b1);
      expect_out("rc1", 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rc2", 1'b1, 32'h8000_0300, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rc3", 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rc4", 1'b1, 32'h8000_0304, 1'b1, 32'h8000_0300);
      // reset in S_WAIT; the stale response must not be buffered
      do_reset();
      lat = 3;
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rs0", 1'b1, 32'h8000_0000, 1'b0, '0);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rs1", 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
      expect_out("rs2", 1'b1, 32'h8000_0000, 1'b0, '0);
      lat = 1;
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rs3", 1'b1, 32'h8000_0000, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rs4", 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      expect_out("rs5", 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
